// File: rtl/stopwatch_cnt.sv
// stopwatch_cnt
// One decimal digit of the stopwatch datapath. The counter runs modulo
// (CNT_MAX+1) and raises a carry so that the next, more significant digit
// can be chained through its cnt_en.
//
// Parameters
//   CNT_MAX : terminal count; the sequence is 0..CNT_MAX (must be < 2**WIDTH)
//   WIDTH   : width of cnt_out
//
// Ports
//   clk     : clock; all state changes on the rising edge
//   rstn    : synchronous reset, active-high (asserted = 1)
//   clear   : synchronous clear, active-high
//   cnt_en  : count enable; one step per enabled clock
//   cnt_out : current count, registered
//   full    : carry / terminal-count flag, combinational
//
// Carry interface: full is high only in the cycle whose rising edge wraps
// this digit. A downstream digit with cnt_en = full therefore steps on the
// same edge that this digit returns to 0. There is no back-pressure.
module stopwatch_cnt #(
  parameter int CNT_MAX = 9,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             cnt_en,
  output logic [WIDTH-1:0] cnt_out,
  output logic             full
);

  localparam logic [WIDTH-1:0] CNT_MAX_C = WIDTH'(CNT_MAX);
  localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);

  logic at_max;
  logic past_max;

  assign at_max   = (cnt_out == CNT_MAX_C);
  // Values above CNT_MAX are unreachable after reset; treat them like the
  // terminal count so the counter recovers on the next enabled edge.
  assign past_max = (cnt_out > CNT_MAX_C);

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_out <= '0;
    end else if (clear) begin
      cnt_out <= '0;
    end else if (cnt_en) begin
      if (at_max || past_max) begin
        cnt_out <= '0;
      end else begin
        cnt_out <= cnt_out + ONE_C;
      end
    end
  end

  // Suppressed by clear and reset so no carry leaks out on a cycle whose
  // edge forces this digit to 0 for a reason other than a wrap.
  assign full = cnt_en & at_max & ~clear & ~rstn;

endmodule

// File: tb/tb_stopwatch_cnt.sv
// tb_stopwatch_cnt
// Bench for stopwatch_cnt: a default digit, a two-digit cascade
// (d1.cnt_en = d0.full) and a CNT_MAX=5 digit, all sharing clk/rstn/clear.
// Expected next counts are pushed before each edge and popped after it.
module tb_stopwatch_cnt;

  logic       clk;
  logic       rstn;
  logic       clear;
  logic       cnt_en;
  logic       en_c;
  logic       en_5;
  logic [3:0] cnt_out;
  logic       full;
  logic [3:0] cnt_d0;
  logic       full_d0;
  logic [3:0] cnt_d1;
  logic       full_d1;
  logic [3:0] cnt_5;
  logic       full_5;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  // reference state, X until the first reset
  logic [3:0] m_main;
  logic [3:0] m_d0;
  logic [3:0] m_d1;
  logic [3:0] m_5;

  stopwatch_cnt dut (
    .clk(clk), .rstn(rstn), .clear(clear), .cnt_en(cnt_en),
    .cnt_out(cnt_out), .full(full)
  );

  stopwatch_cnt u_d0 (
    .clk(clk), .rstn(rstn), .clear(clear), .cnt_en(en_c),
    .cnt_out(cnt_d0), .full(full_d0)
  );

  stopwatch_cnt u_d1 (
    .clk(clk), .rstn(rstn), .clear(clear), .cnt_en(full_d0),
    .cnt_out(cnt_d1), .full(full_d1)
  );

  stopwatch_cnt #(.CNT_MAX(5), .WIDTH(4)) u_mod5 (
    .clk(clk), .rstn(rstn), .clear(clear), .cnt_en(en_5),
    .cnt_out(cnt_5), .full(full_5)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] c, input int mx,
                                     input logic rst, input logic clr, input logic en);
    if (rst)      return 4'd0;
    else if (clr) return 4'd0;
    else if (en)  return (int'(c) >= mx) ? 4'd0 : c + 4'd1;
    else          return c;
  endfunction

  function automatic logic mfull(input logic [3:0] c, input int mx,
                                 input logic rst, input logic clr, input logic en);
    return !rst && !clr && en && (int'(c) == mx);
  endfunction

  // one clock: drive, check carries mid-cycle, push expectation, check after edge
  task automatic step(input logic rst, input logic clr, input logic en,
                      input logic enc, input logic en5);
    logic        e_full0;
    logic [15:0] e;
    rstn   = rst;
    clear  = clr;
    cnt_en = en;
    en_c   = enc;
    en_5   = en5;
    #4;
    e_full0 = mfull(m_d0, 9, rst, clr, enc);
    if (rst || !$isunknown(m_main)) check("full", full, mfull(m_main, 9, rst, clr, en));
    if (rst || !$isunknown(m_d0))   check("full_d0", full_d0, e_full0);
    if (rst || !$isunknown(m_d1))   check("full_d1", full_d1, mfull(m_d1, 9, rst, clr, e_full0));
    if (rst || !$isunknown(m_5))    check("full_5", full_5, mfull(m_5, 5, rst, clr, en5));
    exp_q.push_back({nxt(m_5, 5, rst, clr, en5), nxt(m_d1, 9, rst, clr, e_full0),
                     nxt(m_d0, 9, rst, clr, enc), nxt(m_main, 9, rst, clr, en)});
    m_main = nxt(m_main, 9, rst, clr, en);
    m_d1   = nxt(m_d1, 9, rst, clr, e_full0);
    m_d0   = nxt(m_d0, 9, rst, clr, enc);
    m_5    = nxt(m_5, 5, rst, clr, en5);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cnt_out", cnt_out, e[3:0]);
    check("cnt_d0", cnt_d0, e[7:4]);
    check("cnt_d1", cnt_d1, e[11:8]);
    check("cnt_5", cnt_5, e[15:12]);
  endtask

  // main-digit-only step with the other digits enabled alongside
  task automatic run(input logic rst, input logic clr, input logic en, input int n);
    for (int i = 0; i < n; i++) step(rst, clr, en, en, en);
  endtask

  initial begin
    m_main = 'x;
    m_d0   = 'x;
    m_d1   = 'x;
    m_5    = 'x;
    rstn   = 1'b0;
    clear  = 1'b0;
    cnt_en = 1'b0;
    en_c   = 1'b0;
    en_5   = 1'b0;

    // reset with enable high: count stays 0, carry stays 0
    run(1'b1, 1'b0, 1'b1, 2);
    check("reset_cnt", cnt_out, 4'd0);

    // full wrap 1..9,0
    run(1'b0, 1'b0, 1'b1, 10);
    check("wrap_to_0", cnt_out, 4'd0);
    check("casc_d1_after_10", cnt_d1, 4'd1);

    // hold at 3, resume to 8
    run(1'b0, 1'b0, 1'b1, 3);
    run(1'b0, 1'b0, 1'b0, 2);
    check("hold_3", cnt_out, 4'd3);
    run(1'b0, 1'b0, 1'b1, 5);
    check("resume_8", cnt_out, 4'd8);

    // clear with enable low, then idle at 0
    run(1'b0, 1'b1, 1'b0, 1);
    run(1'b0, 1'b0, 1'b0, 2);
    check("clear_hold_0", cnt_out, 4'd0);

    // clear beats carry at terminal count
    run(1'b0, 1'b0, 1'b1, 9);
    check("at_9", cnt_out, 4'd9);
    run(1'b0, 1'b1, 1'b1, 1);
    check("clear_vs_carry", cnt_out, 4'd0);

    // enable dropped at terminal count: hold 9 with no carry, then wrap
    run(1'b0, 1'b0, 1'b1, 9);
    run(1'b0, 1'b0, 1'b0, 2);
    check("hold_9", cnt_out, 4'd9);
    run(1'b0, 1'b0, 1'b1, 1);
    check("wrap_after_hold", cnt_out, 4'd0);

    // reset mid-count with clear low and enable high
    run(1'b0, 1'b0, 1'b1, 4);
    run(1'b1, 1'b0, 1'b1, 1);
    check("reset_mid", cnt_out, 4'd0);

    // cascade: 100 enabled cycles from 0 wrap both digits back to 0;
    // main and mod-6 digits get random enables meanwhile
    run(1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      if (i == 9) check("casc_d1_10", cnt_d1, 4'd1);
    end
    check("casc_d0_100", cnt_d0, 4'd0);
    check("casc_d1_100", cnt_d1, 4'd0);

    // random tail including occasional clear
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
